regfile_wr_arbiter: RTL
=======================

# regfile_wr_arbiter

Write-port controller for the 32x32 integer register file. Shares the single register-file write port between two writeback requesters: A, the ALU writeback, and B, the load-unit writeback. Uses valid/ready handshakes and round-robin arbitration. Also sequences a full-register clear after reset or on request, because the register file has no reset of its own. Sits between the writeback stage and the register file's rd_wren/rd_addr/rd_data inputs.

## Interface
Parameters:
- NUM_REGS, 32, number of architectural registers.
- ADDR_W, 5, register address width.
- DATA_W, 32, register data width.

Ports:
- clk_i  in  1  clock; all logic on the rising edge.
- rst_i  in  1  synchronous, active-high reset.
- clr_req_i  in  1  request a full clear (registers 1..NUM_REGS-1 written to 0).
- a_valid_i  in  1  requester A has a write.
- a_addr_i  in  ADDR_W  requester A destination register.
- a_data_i  in  DATA_W  requester A write data.
- a_ready_o  out  1  requester A write accepted this cycle.
- b_valid_i / b_addr_i / b_data_i / b_ready_o  same as A, for requester B.
- rd_wren_o  out  1  register-file write enable (registered).
- rd_addr_o  out  ADDR_W  register-file write address (registered).
- rd_data_o  out  DATA_W  register-file write data (registered).
- busy_o  out  1  high while the clear sequence runs.

## Operation
- States:
  - CLEAR: walking the clear sequence.
  - RUN: normal arbitration.
- Reset state:
  - State is CLEAR, clear counter is 1, and round-robin priority is A.
  - rd_wren_o, rd_addr_o and rd_data_o are all 0.
- CLEAR state:
  - Each cycle registers rd_wren_o=1, rd_addr_o=counter, rd_data_o=0, then increments the counter.
  - Register 0 is never written.
  - On the cycle issuing address NUM_REGS-1, the next state is RUN.
  - a_ready_o and b_ready_o are 0.
  - clr_req_i is ignored in this state and does not restart the sequence.
- RUN state, requests:
  - When clr_req_i=1, both readies are 0 that cycle, the next state is CLEAR, and the counter is loaded with 1.
  - Otherwise, with one requester valid, that requester is granted.
  - With both valid, the requester holding priority is granted.
  - Readies are combinational from the valids, the state, clr_req_i and the priority register.
- RUN state, after a grant:
  - Priority passes to the other requester after any grant, contested or not.
  - With no grant, priority is unchanged.
  - The granted address and data are registered onto the rd_* outputs with rd_wren_o=1.
- Writes to address 0: the handshake completes and priority passes, but rd_wren_o stays 0.
- With no grant, rd_wren_o=0. rd_addr_o and rd_data_o hold their last values.
- busy_o equals (state==CLEAR), so it is 1 during reset and the clear walk.

## Timing
- Grant-to-write latency is 1 cycle: a handshake at edge N drives rd_wren_o high in the cycle after edge N.
- The register file commits the write at edge N+1.
- Throughput is one write per cycle. Under continuous dual requests, each requester gets every other cycle.
- Clear after reset release:
  - The first clear write, to address 1, is visible after the first edge with rst_i=0.
  - The clear walk runs NUM_REGS-1 = 31 consecutive write cycles.
  - busy_o is high for those 31 cycles and falls in the cycle after the address-31 write is registered.
  - Readies can first assert in that same cycle.
- Clear requested from RUN:
  - clr_req_i sampled high at edge N means no grant at N, busy_o high from N+1, and the first clear write (address 1) registered at N+1.
  - Total occupancy is 31 cycles.
- Reset asserted mid-clear or mid-operation:
  - The next edge forces all outputs and state to their reset values.
  - Any grant in flight is dropped, and the clear restarts from address 1 after release.
- Requesters must hold valid, addr and data stable until ready. The block does not buffer unaccepted requests.

## Structure
- Shared package regfile_pkg holds:
  - NUM_REGS, ADDR_W and DATA_W constants.
  - The state enum typedef {CLEAR, RUN}.
- Sub-module rr_arb2: 2-way round-robin arbiter with a one-bit priority register and an advance-on-grant input. It is reused elsewhere for other 2-requester resources.
- Everything else is inline: clear counter, FSM and output registers.

## Test plan
- Reset held 3 cycles, then released:
  - rd_wren_o=1 with rd_addr_o=1..31 on 31 consecutive cycles, rd_data_o=0 throughout.
  - busy_o high for those cycles, then a_ready_o/b_ready_o follow their valids.
- A alone, addr 5, data 0xDEADBEEF: a_ready_o=1 that cycle; next cycle rd_wren_o=1, rd_addr_o=5, rd_data_o=0xDEADBEEF.
- A and B valid every cycle (A: x3/0x11111111, B: x4/0x22222222) after clear completes: grants alternate A,B,A,B starting with A, and the rd_* outputs alternate accordingly.
- B alone, addr 0, data 0xFFFFFFFF:
  - b_ready_o=1 and rd_wren_o stays 0.
  - A following contested request from both is granted A first.
- clr_req_i pulsed while A and B are both valid:
  - No ready that cycle, and busy_o high 31 cycles with a 1..31 zero-write walk.
  - A pulse of clr_req_i mid-walk has no effect.
  - The pending requests are granted afterwards.
- rst_i asserted when the clear walk is at address 10: next cycle rd_wren_o=0 and busy_o=1; after release the walk restarts at address 1.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared constants and types for the register-file write-port controller.
package regfile_pkg;

  localparam int NUM_REGS = 32;
  localparam int ADDR_W   = 5;
  localparam int DATA_W   = 32;

  // CLEAR walks registers 1..NUM_REGS-1 writing zero; RUN arbitrates writebacks.
  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } state_e;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter. A one-bit priority register picks the winner
// when both requests are present. After any grant (contested or not),
// priority passes to the requester that lost or was idle.
module rr_arb2 (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [1:0] req_i,
  input  logic       advance_i,
  output logic [1:0] gnt_o
);

  // 0: requester 0 wins a tie, 1: requester 1 wins a tie
  logic prio_q, prio_d;

  // Grant decode from requests and current priority
  always_comb begin
    gnt_o[0] = req_i[0] & (~req_i[1] | ~prio_q);
    gnt_o[1] = req_i[1] & (~req_i[0] |  prio_q);
  end

  // Priority passes to the other requester after a grant is taken
  always_comb begin
    prio_d = prio_q;
    if (advance_i && gnt_o[0]) begin
      prio_d = 1'b1;
    end else if (advance_i && gnt_o[1]) begin
      prio_d = 1'b0;
    end
  end

  // Priority register, requester 0 favoured out of reset
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      prio_q <= 1'b0;
    end else begin
      prio_q <= prio_d;
    end
  end

endmodule

// File: rtl/regfile_wr_arbiter.sv
// Write-port controller for the integer register file. Shares the single
// write port between the ALU (A) and load-unit (B) writebacks using
// round-robin arbitration, and zero-fills registers 1..NUM_REGS-1 after
// reset or on request, since the register file itself has no reset.
//
// Handshake: a requester holds valid/addr/data stable; a write transfers
// on a rising edge where valid and ready are both high. Ready is
// combinational and is never asserted while clearing or when a clear is
// requested in the same cycle.
module regfile_wr_arbiter #(
  parameter int NUM_REGS = regfile_pkg::NUM_REGS,
  parameter int ADDR_W   = regfile_pkg::ADDR_W,
  parameter int DATA_W   = regfile_pkg::DATA_W
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              clr_req_i,
  input  logic              a_valid_i,
  input  logic [ADDR_W-1:0] a_addr_i,
  input  logic [DATA_W-1:0] a_data_i,
  output logic              a_ready_o,
  input  logic              b_valid_i,
  input  logic [ADDR_W-1:0] b_addr_i,
  input  logic [DATA_W-1:0] b_data_i,
  output logic              b_ready_o,
  output logic              rd_wren_o,
  output logic [ADDR_W-1:0] rd_addr_o,
  output logic [DATA_W-1:0] rd_data_o,
  output logic              busy_o
);

  import regfile_pkg::*;

  localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(NUM_REGS - 1);
  localparam logic [ADDR_W-1:0] FIRST_ADDR = ADDR_W'(1);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic              rd_wren_q, rd_wren_d;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
  logic [DATA_W-1:0] rd_data_q, rd_data_d;

  logic              grant_en;
  logic [1:0]        gnt;

  rr_arb2 u_arb (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .req_i     ({b_valid_i & grant_en, a_valid_i & grant_en}),
    .advance_i (grant_en),
    .gnt_o     (gnt)
  );

  // State register
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= CLEAR;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state: leave CLEAR after issuing the last address; a clear request
  // in RUN restarts the walk
  always_comb begin
    state_d = state_q;
    case (state_q)
      CLEAR:   if (cnt_q == LAST_ADDR) state_d = RUN;
      RUN:     if (clr_req_i)          state_d = CLEAR;
      default: state_d = CLEAR;
    endcase
  end

  // FSM outputs: busy flag, grant enable and requester readies
  always_comb begin
    busy_o    = (state_q == CLEAR);
    grant_en  = (state_q == RUN) && !clr_req_i;
    a_ready_o = gnt[0];
    b_ready_o = gnt[1];
  end

  // Datapath next values: clear walk, clear restart, or granted write.
  // A write to register 0 completes the handshake but never enables the port.
  always_comb begin
    cnt_d     = cnt_q;
    rd_wren_d = 1'b0;
    rd_addr_d = rd_addr_q;
    rd_data_d = rd_data_q;
    if (state_q == CLEAR) begin
      rd_wren_d = 1'b1;
      rd_addr_d = cnt_q;
      rd_data_d = '0;
      cnt_d     = cnt_q + FIRST_ADDR;
    end else if (clr_req_i) begin
      cnt_d = FIRST_ADDR;
    end else if (gnt[0]) begin
      rd_wren_d = (a_addr_i != '0);
      rd_addr_d = a_addr_i;
      rd_data_d = a_data_i;
    end else if (gnt[1]) begin
      rd_wren_d = (b_addr_i != '0);
      rd_addr_d = b_addr_i;
      rd_data_d = b_data_i;
    end
  end

  // Clear counter and registered write-port outputs
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q     <= FIRST_ADDR;
      rd_wren_q <= 1'b0;
      rd_addr_q <= '0;
      rd_data_q <= '0;
    end else begin
      cnt_q     <= cnt_d;
      rd_wren_q <= rd_wren_d;
      rd_addr_q <= rd_addr_d;
      rd_data_q <= rd_data_d;
    end
  end

  assign rd_wren_o = rd_wren_q;
  assign rd_addr_o = rd_addr_q;
  assign rd_data_o = rd_data_q;

endmodule
